// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: state encoding shared by the serial adder sequencer
package serial_add_ctrl_pkg;
  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'b00;
  localparam logic [ST_W-1:0] ST_SHIFT = 2'b01;
  localparam logic [ST_W-1:0] ST_DONE  = 2'b10;
endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// serial_add_ctrl_fa_cell: full adder from two half adders plus an OR gate
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fa_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  logic s0, c0, c1;
  half_adder u_ha0 (.a(x),  .b(y), .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(z), .s(s),  .c(c1));
  assign c = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial LSB-first adder sequencer with start/done handshake
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic [ST_W-1:0]  state;
  logic [WIDTH-1:0] op_a, op_b, res, res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry, fa_s, fa_c;
  fa_cell u_fa (.x(op_a[0]), .y(op_b[0]), .z(carry), .s(fa_s), .c(fa_c));
  assign res_nxt = {fa_s, res[WIDTH-1:1]};
  assign ready = state == ST_IDLE;
  assign busy  = state == ST_SHIFT;
  assign done  = state == ST_DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          op_a  <= a;
          op_b  <= b;
          carry <= cin;
          cnt   <= '0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          res   <= res_nxt;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            sum   <= res_nxt;
            cout  <= fa_c;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl at WIDTH 2, 8 and 32
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st2 = 0, st8 = 0, st32 = 0, ci2 = 0, ci8 = 0, ci32 = 0;
  logic [1:0] a2 = 0, b2 = 0, sum2;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic [31:0] a32 = 0, b32 = 0, sum32;
  logic rdy2, rdy8, rdy32, bsy2, bsy8, bsy32, dn2, dn8, dn32, co2, co8, co32;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2),
    .cin(ci2), .ready(rdy2), .busy(bsy2), .done(dn2), .sum(sum2), .cout(co2));
  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
    .cin(ci8), .ready(rdy8), .busy(bsy8), .done(dn8), .sum(sum8), .cout(co8));
  serial_add_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .start(st32), .a(a32), .b(b32),
    .cin(ci32), .ready(rdy32), .busy(bsy32), .done(dn32), .sum(sum32), .cout(co32));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] g_sum(input int w);
    return w == 2 ? {30'b0, sum2} : w == 8 ? {24'b0, sum8} : sum32;
  endfunction
  function automatic logic g_done(input int w);
    return w == 2 ? dn2 : w == 8 ? dn8 : dn32;
  endfunction
  function automatic logic g_busy(input int w);
    return w == 2 ? bsy2 : w == 8 ? bsy8 : bsy32;
  endfunction
  function automatic logic g_ready(input int w);
    return w == 2 ? rdy2 : w == 8 ? rdy8 : rdy32;
  endfunction
  function automatic logic g_cout(input int w);
    return w == 2 ? co2 : w == 8 ? co8 : co32;
  endfunction

  task automatic drive(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci);
    if (w == 2) begin st2 = s; a2 = av[1:0]; b2 = bv[1:0]; ci2 = ci; end
    else if (w == 8) begin st8 = s; a8 = av[7:0]; b8 = bv[7:0]; ci8 = ci; end
    else begin st32 = s; a32 = av; b32 = bv; ci32 = ci; end
  endtask

  // One full operation; during SHIFT the bench scrambles a/b/cin to prove they were captured.
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic ci,
                        input bit detail);
    logic [63:0] exp, mask;
    logic [31:0] old_sum;
    int lat;
    mask = (64'd1 << w) - 1;
    exp = {32'b0, av & mask[31:0]} + {32'b0, bv & mask[31:0]} + {63'b0, ci};
    old_sum = g_sum(w);
    drive(w, 1'b1, av, bv, ci);
    step();
    drive(w, 1'b0, ~av, ~bv, ~ci);
    lat = 0;
    while (!g_done(w) && lat < 100) begin
      if (detail) begin
        chk("shift_ready", {63'b0, g_ready(w)}, 64'd0);
        chk("shift_busy", {63'b0, g_busy(w)}, 64'd1);
        chk("shift_sum_hold", {32'b0, g_sum(w)}, {32'b0, old_sum});
      end
      step();
      lat++;
    end
    chk("latency", 64'(lat), 64'(w));
    chk("sum", {32'b0, g_sum(w)}, exp & mask);
    chk("cout", {63'b0, g_cout(w)}, {63'b0, exp[w]});
    step();
    chk("done_one_cycle", {63'b0, g_done(w)}, 64'd0);
    chk("back_ready", {63'b0, g_ready(w)}, 64'd1);
  endtask

  initial begin
    int dcnt, prev_acc, cyc;
    logic prev_done, busy_after;
    logic [8:0] q[$];
    logic [8:0] e;
    step();
    step();
    chk("rst_ready", {63'b0, rdy8}, 64'd1);
    chk("rst_busy", {63'b0, bsy8}, 64'd0);
    chk("rst_done", {63'b0, dn8}, 64'd0);
    chk("rst_sum", {56'b0, sum8}, 64'd0);
    chk("rst_cout", {63'b0, co8}, 64'd0);
    rst_n = 1'b1;
    step();

    run_op(8, 32'h0F, 32'h01, 1'b0, 1'b1);
    run_op(8, 32'hFF, 32'h01, 1'b0, 1'b1);
    run_op(8, 32'hFF, 32'hFF, 1'b1, 1'b1);

    // Starts during SHIFT and DONE must be dropped.
    drive(8, 1'b1, 32'h12, 32'h34, 1'b0);
    step();
    drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    step();
    drive(8, 1'b1, 32'hAA, 32'h55, 1'b0);
    step();
    st8 = 1'b0;
    dcnt = 0;
    busy_after = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (dcnt > 0 && bsy8) busy_after = 1'b1;
      if (dn8) begin
        dcnt++;
        chk("ign_sum", {56'b0, sum8}, 64'h46);
        st8 = 1'b1;
      end else st8 = 1'b0;
      step();
    end
    chk("ign_done_count", 64'(dcnt), 64'd1);
    chk("ign_no_restart", {63'b0, busy_after}, 64'd0);
    chk("ign_ready", {63'b0, rdy8}, 64'd1);

    // Asynchronous abort mid-shift.
    drive(8, 1'b1, 32'h80, 32'h80, 1'b0);
    step();
    st8 = 1'b0;
    step();
    step();
    step();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {63'b0, rdy8}, 64'd1);
    chk("abort_busy", {63'b0, bsy8}, 64'd0);
    chk("abort_done", {63'b0, dn8}, 64'd0);
    chk("abort_sum", {56'b0, sum8}, 64'd0);
    chk("abort_cout", {63'b0, co8}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    run_op(8, 32'h01, 32'h02, 1'b0, 1'b1);

    // start held high: back-to-back ops at WIDTH+2 spacing.
    prev_acc = -1;
    prev_done = 1'b0;
    for (cyc = 0; cyc < 62; cyc++) begin
      st8 = cyc < 50;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      ci8 = 1'($urandom);
      if (rdy8 && st8) begin
        q.push_back({1'b0, a8} + {1'b0, b8} + {8'b0, ci8});
        if (prev_acc >= 0) chk("b2b_interval", 64'(cyc - prev_acc), 64'd10);
        prev_acc = cyc;
      end
      step();
      if (dn8) begin
        chk("b2b_done_pulse", {63'b0, prev_done}, 64'd0);
        if (q.size() == 0) chk("b2b_unexpected_done", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("b2b_result", {55'b0, co8, sum8}, {55'b0, e});
        end
      end
      prev_done = dn8;
    end
    chk("b2b_drained", 64'(q.size()), 64'd0);
    st8 = 1'b0;
    step();

    for (int n = 0; n < 1000; n++)
      run_op(2, $urandom, $urandom, 1'($urandom), 1'b0);
    for (int n = 0; n < 1000; n++)
      run_op(32, $urandom, $urandom, 1'($urandom), n < 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
